// File: rtl/uart_recv_if.sv
// Receive-side UART bundle: serial line in, byte/status out.
// The receiver takes the slave view and the line driver takes the master view.
interface uart_recv_if;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       rx_busy;

    modport master (output uart_rxd, input uart_data, uart_done, frame_err, rx_busy);
    modport slave  (input uart_rxd, output uart_data, uart_done, frame_err, rx_busy);
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit 2-of-3 majority sampling,
// glitch rejection on the start bit, and early return to IDLE at the stop decision.
module uart_recv #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    uart_recv_if.slave   bus
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;

    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_S0   = 16'(HALF - 1);
    localparam logic [15:0] CNT_S1   = 16'(HALF);
    localparam logic [15:0] CNT_DEC  = 16'(HALF + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_rx_s0, r_rx_s1, r_rx_s2;
    logic [15:0] r_clk_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [1:0]  r_smp;
    logic [7:0]  r_data;
    logic        r_done;
    logic        r_ferr;

    logic w_start_edge, w_wrap, w_decide, w_bit;
    logic w_done_nxt, w_ferr_nxt, w_shift_en;

    assign w_start_edge = r_rx_s2 & ~r_rx_s1;
    assign w_wrap       = (r_clk_cnt == CNT_LAST);
    assign w_decide     = (r_clk_cnt == CNT_DEC);
    // Third sample is the live synchronized value at the decision cycle.
    assign w_bit        = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s1) | (r_smp[1] & r_rx_s1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_start_edge) w_next = START;
            START: begin
                if (w_decide && w_bit) w_next = IDLE;
                else if (w_wrap)       w_next = DATA;
            end
            // bit_cnt reaches 8 only after bit 7 has been decided.
            DATA:  if (w_wrap && r_bit_cnt == 4'd8) w_next = STOP;
            STOP:  if (w_decide) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt = 1'b0;
        w_ferr_nxt = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            DATA: w_shift_en = w_decide;
            STOP: begin
                w_done_nxt = w_decide &  w_bit;
                w_ferr_nxt = w_decide & ~w_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_rx_s0   <= 1'b1;
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_smp     <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_s0 <= bus.uart_rxd;
            r_rx_s1 <= r_rx_s0;
            r_rx_s2 <= r_rx_s1;

            if (r_state == IDLE) r_clk_cnt <= '0;
            else if (w_wrap)     r_clk_cnt <= '0;
            else                 r_clk_cnt <= r_clk_cnt + 16'd1;

            if (r_clk_cnt == CNT_S0) r_smp[0] <= r_rx_s1;
            if (r_clk_cnt == CNT_S1) r_smp[1] <= r_rx_s1;

            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift[r_bit_cnt[2:0]] <= w_bit;
                r_bit_cnt               <= r_bit_cnt + 4'd1;
            end

            r_done <= w_done_nxt;
            r_ferr <= w_ferr_nxt;
            if (w_done_nxt) r_data <= r_shift;
        end
    end

    assign bus.uart_data = r_data;
    assign bus.uart_done = r_done;
    assign bus.frame_err = r_ferr;
    assign bus.rx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_uart_recv.sv
// Scoreboarded random-frame bench for uart_recv at a reduced bit period.
module tb_uart_recv;
    localparam int CLK_FREQ = 6_400_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int HALF     = BPS / 2;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    uart_recv_if uif();

    uart_recv #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (uif)
    );

    always #5 sys_clk = ~sys_clk;

    exp_t       q[$];
    exp_t       e_mon;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        uif.uart_rxd = 1'b1;
        repeat (n) tick();
    endtask

    // One full 10-bit frame; glitch flips the line for a single cycle near each bit centre.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic glitch);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BPS; c++) begin
                uif.uart_rxd = (glitch && c == HALF + 2) ? ~bits[b] : bits[b];
                tick();
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic glitch);
        exp_t e;
        if (stop) begin
            last_good = d;
            e.err = 1'b0;
            e.data = d;
        end else begin
            e.err = 1'b1;
            e.data = last_good;
        end
        q.push_back(e);
        drive_frame(d, stop, glitch);
    endtask

    // Frame cut short by reset in the middle of data bit abort_bit.
    task automatic send_abort(input logic [7:0] d, input int abort_bit);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int b = 0; b <= abort_bit + 1; b++) begin
            for (int c = 0; c < BPS; c++) begin
                uif.uart_rxd = bits[b];
                if (b == abort_bit + 1 && c == HALF) begin
                    sys_rst_n = 1'b0;
                    tick();
                    chk("rst_data", {24'd0, uif.uart_data}, 32'h00);
                    chk("rst_done", {31'd0, uif.uart_done}, 32'd0);
                    chk("rst_ferr", {31'd0, uif.frame_err}, 32'd0);
                    chk("rst_busy", {31'd0, uif.rx_busy}, 32'd0);
                    last_good = 8'h00;
                    sys_rst_n = 1'b1;
                    return;
                end
                tick();
            end
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && (uif.uart_done || uif.frame_err)) begin
            n_vec++;
            if (uif.uart_done && uif.frame_err) begin
                n_err++;
                $display("FAIL done_and_err: both pulses high, expected at most one");
            end else if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b data=%0h, expected none",
                         uif.uart_done, uif.frame_err, uif.uart_data);
            end else begin
                e_mon = q.pop_front();
                if (uif.frame_err !== e_mon.err || uif.uart_data !== e_mon.data) begin
                    n_err++;
                    $display("FAIL frame: err=%0b data=%0h, expected err=%0b data=%0h",
                             uif.frame_err, uif.uart_data, e_mon.err, e_mon.data);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       stop, glitch, prev_stop;
        uif.uart_rxd = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_data", {24'd0, uif.uart_data}, 32'h00);
        chk("reset_done", {31'd0, uif.uart_done}, 32'd0);
        chk("reset_ferr", {31'd0, uif.frame_err}, 32'd0);
        chk("reset_busy", {31'd0, uif.rx_busy}, 32'd0);
        sys_rst_n = 1'b1;
        idle(BPS);

        // Plain frame, with a busy probe in the middle.
        fork
            send(8'hA5, 1'b1, 1'b0);
            begin
                repeat (5 * BPS) tick();
                chk("busy_mid", {31'd0, uif.rx_busy}, 32'd1);
            end
        join
        idle(2 * BPS);
        chk("busy_idle", {31'd0, uif.rx_busy}, 32'd0);

        // Short low pulse must be rejected as a false start.
        uif.uart_rxd = 1'b0;
        repeat (BPS * 300 / 1250) tick();
        idle(2 * BPS);
        chk("glitch_busy", {31'd0, uif.rx_busy}, 32'd0);
        chk("glitch_data", {24'd0, uif.uart_data}, {24'd0, last_good});

        // Good frame, framing error, recovery.
        send(8'h3C, 1'b1, 1'b0);
        idle(BPS);
        send(8'h81, 1'b0, 1'b0);
        idle(2 * BPS);
        chk("ferr_hold", {24'd0, uif.uart_data}, 32'h3C);
        send(8'h7E, 1'b1, 1'b0);

        // Back-to-back, then a glitched frame.
        send(8'h55, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        idle(BPS);
        send(8'hC3, 1'b1, 1'b1);
        idle(2 * BPS);

        // Reset mid data bit 4, then a normal frame.
        send_abort(8'hF0, 4);
        idle(2 * BPS);
        send(8'h12, 1'b1, 1'b0);
        idle(2 * BPS);

        prev_stop = 1'b1;
        for (int i = 0; i < 24; i++) begin
            d      = 8'($urandom);
            stop   = ($urandom_range(0, 5) != 0);
            glitch = $urandom_range(0, 1) == 1;
            if (!prev_stop) idle(BPS + $urandom_range(0, BPS));
            else            idle($urandom_range(0, 2) * BPS);
            send(d, stop, glitch);
            prev_stop = stop;
        end
        idle(3 * BPS);

        chk("pending", q.size(), 32'd0);
        chk("final_busy", {31'd0, uif.rx_busy}, 32'd0);
        chk("final_data", {24'd0, uif.uart_data}, {24'd0, last_good});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, line baud rate.
REQ-003 SHALL have derived constant BPS_CNT = CLK_FREQ/UART_BPS (1250 at defaults) and HALF = BPS_CNT/2 (625).
REQ-004 SHALL have port sys_clk, input, 1 bit: system clock; the only clock, all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port uart_rxd, input, 1 bit: asynchronous UART line, idle high.
REQ-007 SHALL have port uart_data, output, 8 bits: last correctly framed byte received.
REQ-008 SHALL have port uart_done, output, 1 bit: one-cycle pulse when uart_data is updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port rx_busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer (rx_s0, rx_s1), plus a third flop rx_s2 for edge detection.
REQ-012 SHALL detect a start edge when rx_s2=1 and rx_s1=0 while in IDLE.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; frame format 8N1, LSB first.
REQ-014 SHALL use 16-bit clk_cnt, cleared on IDLE->START, incrementing each cycle in non-IDLE states, wrapping BPS_CNT-1 -> 0.
REQ-015 SHALL take three samples of rx_s1 at clk_cnt = HALF-1, HALF, HALF+1 and decide each bit by 2-of-3 majority at clk_cnt = HALF+1.
REQ-016 START: majority 1 -> IDLE, no pulse (glitch rejection); majority 0 -> DATA on the next wrap.
REQ-017 DATA: shift the decided bit into bit index bit_cnt (0..7); after bit 7 is decided, move to STOP on the next wrap.
REQ-018 STOP: on decision, majority 1 -> uart_data <= shift register and uart_done=1 for one cycle; majority 0 -> frame_err=1 for one cycle and uart_data unchanged.
REQ-019 STOP SHALL return to IDLE in the same cycle as the stop decision, not at end of bit, so a start edge about 0.5 bit later is caught.
REQ-020 uart_done and frame_err SHALL never be asserted together and SHALL be registered, asserting in the cycle after the decision edge.
REQ-021 Start edges in non-IDLE states SHALL be ignored.
REQ-022 uart_data SHALL hold its value between frames and SHALL not change on glitch or framing error.
REQ-023 Latency from the uart_rxd falling edge to uart_done SHALL be 2 sync cycles + 9*BPS_CNT + HALF + 2 cycles, within ±1 cycle.

Reset
REQ-024 While sys_rst_n=0 at a sys_clk edge: FSM=IDLE, clk_cnt=0, bit_cnt=0, shift register=0, uart_data=8'h00, uart_done=0, frame_err=0, rx_busy=0, sync flops=1.
REQ-025 Reset mid-frame SHALL abort the frame with no pulse; after release, the next valid start edge SHALL be received normally.

Verification
REQ-026 Send 8N1 0xA5 at 9600 baud (1250 clk/bit) -> exactly one uart_done pulse; uart_data=8'hA5; rx_busy high for about 9.5 bits; frame_err stays 0.
REQ-027 Drive uart_rxd low for 300 cycles, then high -> FSM back to IDLE at clk_cnt=HALF+1; no uart_done/frame_err; uart_data unchanged.
REQ-028 Receive 0x3C, then send 0x81 with stop bit 0 -> frame_err pulse once; uart_data remains 8'h3C; next frame 0x7E is received correctly.
REQ-029 Send back-to-back 0x55, 0xAA with no idle gap -> two uart_done pulses; uart_data=8'h55 then 8'hAA.
REQ-030 Flip one sample per bit of 0xC3 (single-cycle glitch at clk_cnt=HALF) -> majority recovers; uart_data=8'hC3.
REQ-031 Assert sys_rst_n=0 during data bit 4 of 0xF0 -> all outputs 0 next edge; no pulse; after release, 0x12 is received correctly.
